// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I main control: opcodes (instr[6:2]),
// FSM states, trap causes and the ALU-control decode helpers.
package multicycle_control_fsm_pkg;

  localparam logic [4:0] OPCODE_LOAD    = 5'b00000;
  localparam logic [4:0] OPCODE_CUSTOM  = 5'b00010;
  localparam logic [4:0] OPCODE_ARITH_I = 5'b00100;
  localparam logic [4:0] OPCODE_AUIPC   = 5'b00101;
  localparam logic [4:0] OPCODE_STORE   = 5'b01000;
  localparam logic [4:0] OPCODE_ARITH_R = 5'b01100;
  localparam logic [4:0] OPCODE_LUI     = 5'b01101;
  localparam logic [4:0] OPCODE_BRANCH  = 5'b11000;
  localparam logic [4:0] OPCODE_JALR    = 5'b11001;
  localparam logic [4:0] OPCODE_JAL     = 5'b11011;
  localparam logic [4:0] OPCODE_SYSTEM  = 5'b11100;

  localparam logic [1:0] AluAdd    = 2'b00;
  localparam logic [1:0] AluBranch = 2'b01;
  localparam logic [1:0] AluRType  = 2'b10;
  localparam logic [1:0] AluIType  = 2'b11;

  typedef enum logic [2:0] {
    StReset  = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    TrapNone    = 2'b00,
    TrapIllegal = 2'b01,
    TrapTimeout = 2'b10,
    TrapSystem  = 2'b11
  } trap_e;

  function automatic logic is_legal(logic [4:0] opc);
    case (opc)
      OPCODE_LOAD, OPCODE_STORE, OPCODE_BRANCH, OPCODE_JAL, OPCODE_JALR, OPCODE_ARITH_I,
      OPCODE_ARITH_R, OPCODE_AUIPC, OPCODE_LUI, OPCODE_CUSTOM: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  endfunction

  // Register-register style ops take the second operand from rs2, everything else an immediate.
  function automatic logic alu_src_of(logic [4:0] opc);
    case (opc)
      OPCODE_ARITH_R, OPCODE_BRANCH, OPCODE_CUSTOM: alu_src_of = 1'b0;
      default: alu_src_of = 1'b1;
    endcase
  endfunction

  function automatic logic [1:0] alu_op_of(logic [4:0] opc);
    case (opc)
      OPCODE_BRANCH:                 alu_op_of = AluBranch;
      OPCODE_ARITH_R, OPCODE_CUSTOM: alu_op_of = AluRType;
      OPCODE_ARITH_I:                alu_op_of = AluIType;
      default:                       alu_op_of = AluAdd;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle main control: walks each instruction through FETCH/DECODE/EXEC/MEM/WB,
// with bus-timeout and illegal/SYSTEM traps into an absorbing HALT.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int unsigned CUSTOM_LAT = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] op,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic       jump,
  output logic       mem_read,
  output logic       mem_write,
  output logic       dmem_req,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic       busy,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam int unsigned CntMax = (TIMEOUT > CUSTOM_LAT) ? TIMEOUT : CUSTOM_LAT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CustomLast  = CntW'(CUSTOM_LAT - 1);
  localparam logic [CntW-1:0] CntSat      = CntW'(CntMax);

  state_e          state_q;
  logic [4:0]      op_q;
  logic [CntW-1:0] cnt_q;
  trap_e           cause_q;

  // One counter serves both ack-wait timeout and custom-op latency; it clears on every
  // state change and otherwise counts (saturating) while the state holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StReset;
      op_q    <= '0;
      cnt_q   <= '0;
      cause_q <= TrapNone;
    end else begin
      cnt_q <= (cnt_q == CntSat) ? cnt_q : cnt_q + 1'b1;
      case (state_q)
        StReset: begin
          state_q <= StFetch;
          cnt_q   <= '0;
        end
        StFetch: begin
          if (imem_ack) begin
            state_q <= StDecode;
            cnt_q   <= '0;
          end else if (cnt_q == TimeoutLast) begin
            state_q <= StHalt;
            cause_q <= TrapTimeout;
          end
        end
        StDecode: begin
          op_q  <= op;
          cnt_q <= '0;
          if (op == OPCODE_SYSTEM) begin
            state_q <= StHalt;
            cause_q <= TrapSystem;
          end else if (!is_legal(op)) begin
            state_q <= StHalt;
            cause_q <= TrapIllegal;
          end else begin
            state_q <= StExec;
          end
        end
        StExec: begin
          if (op_q != OPCODE_CUSTOM || cnt_q == CustomLast) begin
            cnt_q <= '0;
            if (op_q == OPCODE_BRANCH) begin
              state_q <= StFetch;
            end else if (op_q == OPCODE_LOAD || op_q == OPCODE_STORE) begin
              state_q <= StMem;
            end else begin
              state_q <= StWb;
            end
          end
        end
        StMem: begin
          if (dmem_ack) begin
            cnt_q   <= '0;
            state_q <= (op_q == OPCODE_LOAD) ? StWb : StFetch;
          end else if (cnt_q == TimeoutLast) begin
            state_q <= StHalt;
            cause_q <= TrapTimeout;
          end
        end
        StWb: begin
          state_q <= StFetch;
          cnt_q   <= '0;
        end
        StHalt: ;
        default: state_q <= StReset;
      endcase
    end
  end

  // Moore decode of the registered state; only the fetch-done strobes look at imem_ack.
  always_comb begin
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    alu_op     = AluAdd;
    trap       = 1'b0;
    trap_cause = TrapNone;
    case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        ir_write = imem_ack;
        pc_write = imem_ack;
      end
      StExec: begin
        branch  = (op_q == OPCODE_BRANCH);
        jump    = (op_q == OPCODE_JAL) || (op_q == OPCODE_JALR);
        alu_src = alu_src_of(op_q);
        alu_op  = alu_op_of(op_q);
      end
      StMem: begin
        mem_read  = (op_q == OPCODE_LOAD);
        mem_write = (op_q == OPCODE_STORE);
        alu_src   = alu_src_of(op_q);
        alu_op    = alu_op_of(op_q);
      end
      StWb: begin
        reg_write  = 1'b1;
        mem_to_reg = (op_q == OPCODE_LOAD);
      end
      StHalt: begin
        trap       = 1'b1;
        trap_cause = cause_q;
      end
      default: ;
    endcase
    dmem_req = mem_read | mem_write;
    busy     = (state_q != StReset) && (state_q != StHalt);
  end

endmodule
